wptr_full: RTL and testbench

Write-side pointer and full-flag generator for the asynchronous FIFO; the write-domain counterpart of the read-pointer/empty logic. It keeps a binary write address for the dual-port memory and a Gray-coded write pointer for the read domain. It compares that pointer against the read pointer, already synchronized into the write clock domain, to drive full, almost-full, fill-level and overflow indications. It sits between the write client, the FIFO memory write port and the write-to-read pointer synchronizer.

---
 rtl/wptr_full.sv | 81 ++++++++
 tb/tb_wptr_full.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// Write-side pointer and full/almost-full/level generator for the asynchronous FIFO.
// Optional sticky overflow flag enabled by defining WPTR_OVERFLOW_FLAG_EN.
module wptr_full #(
  parameter int unsigned address_width     = 4,
  parameter int unsigned almost_full_level = 14
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic                     winc,
  input  logic [address_width:0]   wq2_rptr,
  output logic [address_width-1:0] waddr,
  output logic [address_width:0]   wptr,
  output logic                     wfull,
  output logic                     wafull,
  output logic [address_width:0]   wlevel,
  output logic                     wovf
);

  localparam logic [address_width:0] AF_LEVEL = (address_width+1)'(almost_full_level);

  logic [address_width:0] wbin;
  logic [address_width:0] wbin_next;
  logic [address_width:0] wgray_next;
  logic [address_width:0] rbin_s;
  logic [address_width:0] rptr_full_match;
  logic [address_width:0] wlevel_next;
  logic                   wadv;
  logic                   wfull_next;
  logic                   wafull_next;

  assign wadv = winc & ~wfull;

  always_comb begin
    wbin_next  = wbin + {{address_width{1'b0}}, wadv};
    wgray_next = (wbin_next >> 1) ^ wbin_next;
  end

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    rbin_s = '0;
    for (int unsigned j = 0; j <= address_width; j++)
      rbin_s[j] = ^(wq2_rptr >> j);
  end

  always_comb begin
    rptr_full_match = {~wq2_rptr[address_width:address_width-1], wq2_rptr[address_width-2:0]};
    wfull_next      = (wgray_next == rptr_full_match);
    wlevel_next     = wbin_next - rbin_s;
    wafull_next     = (wlevel_next >= AF_LEVEL);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wafull <= 1'b0;
      wlevel <= '0;
    end else begin
      wbin   <= wbin_next;
      wptr   <= wgray_next;
      wfull  <= wfull_next;
      wafull <= wafull_next;
      wlevel <= wlevel_next;
    end
  end

  assign waddr = wbin[address_width-1:0];

`ifdef WPTR_OVERFLOW_FLAG_EN
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst)
      wovf <= 1'b0;
    else if (winc && wfull)
      wovf <= 1'b1;
  end
`else
  assign wovf = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full: counter-based model checked every cycle plus literal checkpoints.
module tb_wptr_full;

  logic       wclk;
  logic       wrst;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       wafull;
  logic [4:0] wlevel;
  logic       wovf;

  int total = 0;
  int bad   = 0;

  // Model state: plain counts of accepted writes and of reads the write side has seen.
  int m_wr  = 0;
  int rd_cnt = 0;
  int m_lvl = 0;
  bit m_ovf = 0;
  bit ovf_expected;

  wptr_full #(.address_width(4), .almost_full_level(14)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
    .waddr(waddr), .wptr(wptr), .wfull(wfull), .wafull(wafull),
    .wlevel(wlevel), .wovf(wovf)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] to_gray(input int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_rd(input int n);
    rd_cnt   = n;
    wq2_rptr = to_gray(n);
  endtask

  task automatic step();
    @(posedge wclk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wptr"},   int'(wptr),   0);
    chk({tag, "_waddr"},  int'(waddr),  0);
    chk({tag, "_wfull"},  int'(wfull),  0);
    chk({tag, "_wafull"}, int'(wafull), 0);
    chk({tag, "_wlevel"}, int'(wlevel), 0);
    chk({tag, "_wovf"},   int'(wovf),   0);
  endtask

  always @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      m_wr  = 0;
      m_lvl = 0;
      m_ovf = 0;
    end else begin
      if (winc && m_lvl == 16) m_ovf = 1;
      else if (winc) m_wr = m_wr + 1;
      m_lvl = (m_wr - rd_cnt) & 31;
    end
  end

  always @(negedge wclk) begin
    if (!wrst) begin
      chk("m_wptr",   int'(wptr),   int'(to_gray(m_wr)));
      chk("m_waddr",  int'(waddr),  m_wr & 15);
      chk("m_wlevel", int'(wlevel), m_lvl);
      chk("m_wfull",  int'(wfull),  int'(m_lvl == 16));
      chk("m_wafull", int'(wafull), int'(m_lvl >= 14));
      chk("m_wovf",   int'(wovf),   int'(m_ovf && ovf_expected));
    end
  end

  int  max_lvl;
  bit  saw_full;
  int  hist[$];

  initial begin
`ifdef WPTR_OVERFLOW_FLAG_EN
    ovf_expected = 1'b1;
`else
    ovf_expected = 1'b0;
`endif
    wrst = 1'b0;
    winc = 1'b1;
    wq2_rptr = 5'b10110;
    #1 wrst = 1'b1;
    #2 chk_reset_outputs("rst_async");

    // Hold reset across a couple of edges with garbage, then start clean.
    step();
    step();
    winc = 1'b0;
    set_rd(0);
    wrst = 1'b0;

    // Fill from empty.
    winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 13) chk("fill13_wafull", int'(wafull), 0);
      if (i == 14) begin
        chk("fill14_wafull", int'(wafull), 1);
        chk("fill14_wlevel", int'(wlevel), 14);
      end
      if (i == 15) chk("fill15_wfull", int'(wfull), 0);
    end
    chk("fill16_wfull",  int'(wfull),  1);
    chk("fill16_wptr",   int'(wptr),   int'(5'b11000));
    chk("fill16_waddr",  int'(waddr),  0);
    chk("fill16_wlevel", int'(wlevel), 16);

    // Overflow attempts while full.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovf_wptr",   int'(wptr),   int'(5'b11000));
      chk("ovf_wlevel", int'(wlevel), 16);
    end
    winc = 1'b0;
    step();
    step();
    chk("ovf_sticky", int'(wovf), int'(ovf_expected));

    // Read-side release of one entry.
    set_rd(1);
    step();
    chk("rel_wfull",  int'(wfull),  0);
    chk("rel_wlevel", int'(wlevel), 15);
    chk("rel_wafull", int'(wafull), 1);
    winc = 1'b1;
    step();
    winc = 1'b0;
    chk("rel_refill_wfull", int'(wfull), 1);
    chk("rel_refill_wptr",  int'(wptr),  int'(5'b11001));

    // Wrap-around with the read pointer trailing by two cycles.
    wrst = 1'b1;
    #1 set_rd(0);
    #1 wrst = 1'b0;
    max_lvl  = 0;
    saw_full = 0;
    hist.delete();
    winc = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      hist.push_back(m_wr);
      if (hist.size() > 2) set_rd(hist[hist.size()-3]);
      if (int'(wlevel) > max_lvl) max_lvl = int'(wlevel);
      if (wfull) saw_full = 1;
      if (i == 31) chk("wrap31_wptr", int'(wptr), int'(5'b10000));
      if (i == 32) begin
        chk("wrap32_wptr",  int'(wptr),  0);
        chk("wrap32_waddr", int'(waddr), 0);
      end
    end
    winc = 1'b0;
    chk("wrap_never_full", int'(saw_full), 0);
    chk("wrap_lvl_le3", int'(max_lvl <= 3), 1);

    // Reset mid-fill, pulsed between edges.
    wrst = 1'b1;
    #1 set_rd(0);
    #1 wrst = 1'b0;
    winc = 1'b1;
    for (int i = 0; i < 10; i++) step();
    winc = 1'b0;
    chk("mid_waddr10", int'(waddr), 10);
    wrst = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    #1 wrst = 1'b0;
    winc = 1'b1;
    step();
    winc = 1'b0;
    chk("mid_after_waddr", int'(waddr), 1);
    chk("mid_after_wptr",  int'(wptr),  int'(5'b00001));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
